// File: rtl/pkt_stream_arbiter.sv
// rtl/pkt_stream_arbiter.sv - packet-atomic round-robin merge of NUM_PORTS streams
module pkt_stream_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_enable,
  input  logic [NUM_PORTS-1:0]            in_tvalid,
  output logic [NUM_PORTS-1:0]            in_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]            in_tlast,
  output logic                            out_tvalid,
  input  logic                            out_tready,
  output logic [DATA_WIDTH-1:0]           out_tdata,
  output logic                            out_tlast,
  output logic                            busy,
  output logic [IDX_W-1:0]                grant_idx,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                     grant_idx_q, grant_idx_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic [NUM_PORTS-1:0]  req;
  logic [IDX_W:0]        cand;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  beat_xfer;

  assign req = in_tvalid & port_enable;

  // Rotating-priority search starting at rr_ptr; cand wraps modulo NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      end
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Granted-port mux; in_tready depends only on state, grant and out_tready.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    in_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        g_valid = in_tvalid[i];
        g_last  = in_tlast[i];
        g_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == BUSY) begin
          in_tready[i] = out_tready;
        end
      end
    end
  end

  assign out_tvalid = (state_q == BUSY) && g_valid;
  assign out_tdata  = out_tvalid ? g_data : '0;
  assign out_tlast  = out_tvalid && g_last;
  assign beat_xfer  = out_tvalid && out_tready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (beat_xfer && g_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx_q + IDX_W'(1);
          pkt_count_d[grant_idx_q] = pkt_count_q[grant_idx_q] + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_idx_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// tb/tb_pkt_stream_arbiter.sv - scoreboard bench with a cycle-level reference model
module tb_pkt_stream_arbiter;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_enable;
  logic [NP-1:0]     in_tvalid;
  logic [NP-1:0]     in_tready;
  logic [NP*DW-1:0]  in_tdata;
  logic [NP-1:0]     in_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic [DW-1:0]     out_tdata;
  logic              out_tlast;
  logic              busy;
  logic [IW-1:0]     grant_idx;
  logic [NP*CW-1:0]  pkt_count;

  pkt_stream_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .port_enable(port_enable),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .busy(busy), .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t src_q[NP][$];
  beat_t exp_q[$];
  int    dut_grants[$];
  int    tr_pat[$];
  int    gap_pct = 0;
  int    tr_mode = 0;
  int    sent[NP];
  int    stall_at[NP];
  int    stall_rem[NP];
  int    vrise_cyc[NP];
  int    pkt_start_cyc = 0;

  bit    m_busy = 1'b0;
  int    m_g = 0;
  int    m_rr = 0;
  int    m_cnt[NP];

  int    rr_exp[6] = '{0, 1, 3, 0, 1, 3};
  int    en_exp[4] = '{3, 1, 3, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: spec rules applied to the bench-driven inputs each cycle.
  always @(negedge clk) begin : model
    logic [NP-1:0] req;
    logic [NP-1:0] exp_rdy;
    exp_rdy = m_busy ? (NP'(out_tready) << m_g) : '0;
    chk("busy", busy, m_busy);
    chk("grant_idx", grant_idx, m_g);
    chk("in_tready", in_tready, exp_rdy);
    chk("out_tvalid", out_tvalid, m_busy && in_tvalid[m_g]);
    for (int i = 0; i < NP; i++) chk($sformatf("pkt_count%0d", i), pkt_count[i*CW +: CW], m_cnt[i]);
    if (m_busy) begin
      if (in_tvalid[m_g] && out_tready && src_q[m_g].size() > 0) begin
        exp_q.push_back(src_q[m_g][0]);
        if (src_q[m_g][0].l) begin
          m_cnt[m_g] = (m_cnt[m_g] + 1) % (1 << CW);
          m_busy = 1'b0;
          m_rr = (m_g + 1) % NP;
        end
      end
    end else begin
      req = in_tvalid & port_enable;
      for (int k = 0; k < NP; k++) begin
        if (!m_busy && req[(m_rr + k) % NP]) begin
          m_g = (m_rr + k) % NP;
          m_busy = 1'b1;
        end
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      m_g = 0;
      m_rr = 0;
      for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    end
  end

  // Monitor: pops expected beats whenever the merged stream transfers.
  initial begin : monitor
    bit    prev_busy;
    bit    seen;
    beat_t e;
    prev_busy = 1'b0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (busy && !prev_busy) begin
        dut_grants.push_back(int'(grant_idx));
        seen = 1'b0;
      end
      prev_busy = busy;
      if (out_tvalid && !seen) begin
        seen = 1'b1;
        pkt_start_cyc = cyc;
      end
      if (!out_tvalid) begin
        chk("idle_tdata_zero", out_tdata, 0);
        chk("idle_tlast_zero", out_tlast, 0);
      end
      if (out_tvalid && out_tready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_tdata", out_tdata, e.d);
          chk("out_tlast", out_tlast, e.l);
        end
      end
    end
  end

  // Source drivers and out_tready generator.
  initial begin : driver
    logic [NP-1:0] hs;
    beat_t         b;
    logic          v;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    forever begin
      @(negedge clk);
      #3;
      hs = in_tvalid & in_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (hs[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          sent[i]++;
        end
        if (src_q[i].size() == 0) begin
          v = 1'b0;
          b = '0;
        end else begin
          if (stall_rem[i] > 0 && sent[i] == stall_at[i]) begin
            v = 1'b0;
            stall_rem[i]--;
          end else begin
            v = ($urandom_range(0, 99) >= gap_pct);
          end
          b = src_q[i][0];
        end
        if (v && !in_tvalid[i]) vrise_cyc[i] = cyc;
        in_tvalid[i] = v;
        in_tdata[i*DW +: DW] = b.d;
        in_tlast[i] = b.l;
      end
      if (tr_mode == 0) out_tready = 1'b1;
      else if (tr_mode == 1) out_tready = ($urandom_range(0, 99) < 70);
      else out_tready = (tr_pat.size() > 0) ? (tr_pat.pop_front() != 0) : 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_beat(input int p, input logic [DW-1:0] d, input logic l);
    beat_t bt;
    bt.d = d;
    bt.l = l;
    src_q[p].push_back(bt);
  endtask

  task automatic push_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) push_beat(p, DW'($urandom), k == len - 1);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget, output int n);
    n = 0;
    while (!(all_empty() && !busy && in_tvalid == '0) && n < budget) begin
      step(1);
      n++;
    end
    chk({name, "_drain_in_time"}, n < budget, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      stall_rem[i] = 0;
      sent[i] = 0;
    end
    tr_pat.delete();
    step(1);
    rst = 1'b0;
  endtask

  function automatic int grant_at(input int k);
    return (k < dut_grants.size()) ? dut_grants[k] : -1;
  endfunction

  initial begin : stimulus
    int n;
    int base;
    rst = 1'b1;
    port_enable = '1;
    for (int i = 0; i < NP; i++) begin
      sent[i] = 0; stall_at[i] = 0; stall_rem[i] = 0; vrise_cyc[i] = 0; m_cnt[i] = 0;
    end
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_busy", busy, 0);
    chk("rst_in_tready", in_tready, 0);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_pkt_count", pkt_count, 0);

    // Single 3-beat packet on port 2.
    push_beat(2, 16'h3005, 1'b0);
    push_beat(2, 16'h1111, 1'b0);
    push_beat(2, 16'h2222, 1'b1);
    wait_drain("single", 50, n);
    chk("single_first_beat_latency", pkt_start_cyc - vrise_cyc[2], 1);
    chk("single_count2", pkt_count[2*CW +: CW], 1);
    chk("single_grant_idx", grant_idx, 2);
    chk("single_grant_log", grant_at(0), 2);

    // Round robin from a fresh pointer: ports 0,1,3 with two 2-beat packets each.
    do_reset();
    base = dut_grants.size();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 2); push_pkt(1, 2); push_pkt(3, 2);
    end
    wait_drain("rr", 100, n);
    chk("rr_grant_total", dut_grants.size() - base, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), grant_at(base + k), rr_exp[k]);
    chk("rr_count0", pkt_count[0*CW +: CW], 2);
    chk("rr_count1", pkt_count[1*CW +: CW], 2);
    chk("rr_count3", pkt_count[3*CW +: CW], 2);

    // Backpressure on a 4-beat packet from port 1 (first pattern entry covers the arbitration cycle).
    tr_mode = 2;
    tr_pat = '{1, 1, 0, 0, 1};
    push_pkt(1, 4);
    wait_drain("bp", 50, n);
    tr_mode = 0;
    chk("bp_count1", pkt_count[1*CW +: CW], 3);
    chk("bp_scoreboard_empty", exp_q.size(), 0);

    // Enable mask 1010 with all ports requesting; pointer starts at 2.
    port_enable = 4'b1010;
    base = dut_grants.size();
    for (int p = 0; p < NP; p++) begin
      push_pkt(p, 3); push_pkt(p, 3);
    end
    n = 0;
    while (!(src_q[1].size() == 0 && src_q[3].size() == 0 && !busy) && n < 200) begin
      step(1);
      n++;
    end
    chk("mask_in_time", n < 200, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("mask_order%0d", k), grant_at(base + k), en_exp[k]);
    push_pkt(1, 2); push_pkt(1, 2); push_pkt(3, 2);
    n = 0;
    while (!(busy && grant_idx == 2'd1) && n < 100) begin
      step(1);
      n++;
    end
    chk("mask_port1_granted", n < 100, 1);
    port_enable = 4'b1000;
    step(40);
    chk("mask_grant_total", dut_grants.size() - base, 6);
    chk("mask_grant4", grant_at(base + 4), 3);
    chk("mask_grant5", grant_at(base + 5), 1);
    chk("mask_port1_left", src_q[1].size(), 2);
    chk("mask_count1", pkt_count[1*CW +: CW], 6);
    chk("mask_count3", pkt_count[3*CW +: CW], 5);
    chk("mask_count0", pkt_count[0*CW +: CW], 2);

    // Mid-packet stall holds the grant; reset abandons it and restarts from port 0.
    do_reset();
    port_enable = '1;
    push_pkt(0, 3);
    stall_at[0] = 1;
    stall_rem[0] = 1000;
    n = 0;
    while (sent[0] < 1 && n < 50) begin
      step(1);
      n++;
    end
    chk("stall_first_beat", sent[0], 1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("stall_busy", busy, 1);
      chk("stall_grant", grant_idx, 0);
    end
    do_reset();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_tready", in_tready, 0);
    chk("post_rst_counts", pkt_count, 0);
    base = dut_grants.size();
    push_pkt(3, 1);
    push_pkt(0, 1);
    wait_drain("post_rst", 50, n);
    chk("post_rst_first_grant", grant_at(base), 0);
    chk("post_rst_second_grant", grant_at(base + 1), 3);

    // 17 back-to-back single-beat packets: 2 cycles each, counter wraps at 16.
    do_reset();
    for (int k = 0; k < 17; k++) push_pkt(0, 1);
    wait_drain("wrap", 200, n);
    chk("wrap_cycles", n, 35);
    chk("wrap_count0", pkt_count[0*CW +: CW], 1);

    // Randomised traffic, enables and backpressure, then drain.
    do_reset();
    gap_pct = 25;
    tr_mode = 1;
    for (int c = 0; c < 400; c++) begin
      step(1);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, NP - 1);
        if (src_q[n].size() < 12) push_pkt(n, $urandom_range(1, 5));
      end
      if ($urandom_range(0, 24) == 0) port_enable = NP'($urandom);
    end
    port_enable = '1;
    gap_pct = 0;
    tr_mode = 0;
    wait_drain("random", 3000, n);
    step(2);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
